demux64_2: RTL and testbench

Steering buffer routing a stream of 64-bit words to one of two consumers; the write-direction counterpart of the 2:1 64-bit operand mux. Sits between a producer stage (e.g. execute result) and two downstream stages (e.g. memory path and register write-back). Each destination has its own small FIFO, so one stalled consumer does not block words bound for the other unless the producer's next word targets the stalled side.

---
 rtl/demux64_pkg.sv | 9 +
 rtl/demux_fifo.sv | 66 ++++++
 rtl/demux64_2.sv | 68 ++++++
 tb/tb_demux64_2.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/demux64_pkg.sv
// Shared defaults and word type for the demux64_2 steering buffer.
package demux64_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int DEPTH_DEF = 2;

    typedef logic [WIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/demux_fifo.sv
// Single-clock synchronous FIFO used as one destination buffer of demux64_2.
// The head is read straight from storage, and head_data is forced to zero while the FIFO is empty.
module demux_fifo
    import demux64_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap naturally because DEPTH is a power of two. The count carries
    // one extra bit so that the full state (DEPTH) differs from the empty state (0).
    assign full       = (count_q == CW'(DEPTH));
    assign head_valid = (count_q != '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && head_valid;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;

endmodule

// File: rtl/demux64_2.sv
// Steers a producer's word stream into one of two per-destination FIFOs.
// Optional macro DEMUX64_BROADCAST_EN adds a bcast input that pushes one word into both FIFOs.
module demux64_2
    import demux64_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     sel,
`ifdef DEMUX64_BROADCAST_EN
    input  logic                     bcast,
`endif
    output logic                     outOne_valid,
    input  logic                     outOne_ready,
    output logic [WIDTH-1:0]         outOne_data,
    output logic [$clog2(DEPTH):0]   outOne_count,
    output logic                     outZero_valid,
    input  logic                     outZero_ready,
    output logic [WIDTH-1:0]         outZero_data,
    output logic [$clog2(DEPTH):0]   outZero_count
);

    logic to_one, to_zero;
    logic full_one, full_zero;
    logic accept;

`ifdef DEMUX64_BROADCAST_EN
    assign to_one  = bcast || sel;
    assign to_zero = bcast || !sel;
`else
    assign to_one  = sel;
    assign to_zero = !sel;
`endif

    // Ready looks only at occupancy. A same-cycle pop is ignored so that no ready->ready path exists.
    assign in_ready = !reset && !(to_one && full_one) && !(to_zero && full_zero);
    assign accept   = in_valid && in_ready;

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_one (
        .clk        (clk),
        .reset      (reset),
        .push       (accept && to_one),
        .push_data  (in_data),
        .pop        (outOne_ready),
        .head_valid (outOne_valid),
        .head_data  (outOne_data),
        .count      (outOne_count),
        .full       (full_one)
    );

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_zero (
        .clk        (clk),
        .reset      (reset),
        .push       (accept && to_zero),
        .push_data  (in_data),
        .pop        (outZero_ready),
        .head_valid (outZero_valid),
        .head_data  (outZero_data),
        .count      (outZero_count),
        .full       (full_zero)
    );

endmodule

// File: tb/tb_demux64_2.sv
// Scoreboard bench for demux64_2: per-port expected-word queues stand in for the two FIFOs.
module tb_demux64_2;

    localparam int WIDTH = 64;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             sel;
    logic             bc;
`ifdef DEMUX64_BROADCAST_EN
    logic             bcast;
`endif
    logic             outOne_valid, outOne_ready;
    logic [WIDTH-1:0] outOne_data;
    logic [CW-1:0]    outOne_count;
    logic             outZero_valid, outZero_ready;
    logic [WIDTH-1:0] outZero_data;
    logic [CW-1:0]    outZero_count;

    logic [WIDTH-1:0] q_one[$];
    logic [WIDTH-1:0] q_zero[$];
    int               compared   = 0;
    int               mismatched = 0;
    bit               run        = 1'b0;
    logic             exp_rdy;

    demux64_2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .sel           (sel),
`ifdef DEMUX64_BROADCAST_EN
        .bcast         (bcast),
`endif
        .outOne_valid  (outOne_valid),
        .outOne_ready  (outOne_ready),
        .outOne_data   (outOne_data),
        .outOne_count  (outOne_count),
        .outZero_valid (outZero_valid),
        .outZero_ready (outZero_ready),
        .outZero_data  (outZero_data),
        .outZero_count (outZero_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the DUT against the queues, then retires the words consumed at the coming edge.
    always @(negedge clk) begin
        if (run) begin
            if (reset)   exp_rdy = 1'b0;
            else if (bc) exp_rdy = (q_one.size() < DEPTH) && (q_zero.size() < DEPTH);
            else if (sel) exp_rdy = (q_one.size() < DEPTH);
            else         exp_rdy = (q_zero.size() < DEPTH);
            check("in_ready", WIDTH'(in_ready), WIDTH'(exp_rdy));
            check("outOne_count", WIDTH'(outOne_count), WIDTH'(q_one.size()));
            check("outZero_count", WIDTH'(outZero_count), WIDTH'(q_zero.size()));
            check("outOne_valid", WIDTH'(outOne_valid), WIDTH'(q_one.size() > 0));
            check("outZero_valid", WIDTH'(outZero_valid), WIDTH'(q_zero.size() > 0));
            check("outOne_data", outOne_data, (q_one.size() > 0) ? q_one[0] : '0);
            check("outZero_data", outZero_data, (q_zero.size() > 0) ? q_zero[0] : '0);
            if (outOne_ready && q_one.size() > 0)   void'(q_one.pop_front());
            if (outZero_ready && q_zero.size() > 0) void'(q_zero.pop_front());
        end
    end

    // One cycle of stimulus. After the monitor has run, the words this edge accepts are queued.
    task automatic cyc(input logic v, input logic s, input logic b, input logic [WIDTH-1:0] d,
                       input logic r1, input logic r0, input logic rs);
        @(posedge clk);
        #1;
        in_valid      = v;
        sel           = s;
        bc            = b;
`ifdef DEMUX64_BROADCAST_EN
        bcast         = b;
`endif
        in_data       = d;
        outOne_ready  = r1;
        outZero_ready = r0;
        reset         = rs;
        @(negedge clk);
        #1;
        if (rs) begin
            q_one.delete();
            q_zero.delete();
        end else if (v && in_ready) begin
            if (b || s)  q_one.push_back(d);
            if (b || !s) q_zero.push_back(d);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; sel = 1'b0; bc = 1'b0; in_data = '0;
        outOne_ready = 1'b0; outZero_ready = 1'b0;
`ifdef DEMUX64_BROADCAST_EN
        bcast = 1'b0;
`endif
        @(posedge clk);
        #1 run = 1'b1;
        cyc(0, 0, 0, '0, 0, 0, 1);
        // Single word into port one
        cyc(1, 1, 0, 64'hFFFFFFFFFFFFFFFF, 0, 0, 0);
        // Port zero fills while its consumer stalls; port one still accepts
        cyc(1, 0, 0, 64'h1, 0, 0, 0);
        cyc(1, 0, 0, 64'h2, 0, 0, 0);
        cyc(1, 0, 0, 64'h99, 0, 0, 0);
        cyc(1, 1, 0, 64'h3, 0, 0, 0);
        // Drain port zero
        cyc(0, 0, 0, '0, 0, 1, 0);
        cyc(0, 0, 0, '0, 0, 1, 0);
        cyc(0, 0, 0, '0, 0, 1, 0);
        // Port one full; push+pop on port zero at count 1
        cyc(1, 1, 0, 64'h77, 0, 0, 0);
        cyc(1, 0, 0, 64'h10, 0, 0, 0);
        cyc(1, 0, 0, 64'h11, 0, 1, 0);
        cyc(0, 0, 0, '0, 0, 1, 0);
        cyc(0, 0, 0, '0, 0, 0, 0);
        // Fill both ports, then reset mid-stream
        cyc(1, 0, 0, 64'h20, 0, 0, 0);
        cyc(1, 0, 0, 64'h21, 0, 0, 0);
        cyc(1, 0, 0, 64'h22, 1, 0, 1);
        cyc(0, 0, 0, '0, 0, 0, 0);
        cyc(0, 1, 0, '0, 0, 0, 0);
`ifdef DEMUX64_BROADCAST_EN
        cyc(1, 0, 1, 64'hA5A5A5A5A5A5A5A5, 0, 0, 0);
        cyc(1, 0, 1, 64'h5A5A5A5A5A5A5A5A, 0, 0, 0);
        cyc(0, 0, 0, '0, 1, 0, 0);
        cyc(1, 1, 1, 64'hBEEF, 0, 0, 0);
        cyc(0, 0, 0, '0, 1, 1, 0);
        cyc(0, 0, 0, '0, 1, 1, 0);
`endif
        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic             b;
            logic [WIDTH-1:0] d;
            b = 1'b0;
`ifdef DEMUX64_BROADCAST_EN
            b = ($urandom_range(0, 3) == 0);
`endif
            d = {$urandom, $urandom};
            if (i % 500 == 250) d = '1;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1), b, d,
                $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 99) == 0);
        end
        cyc(0, 0, 0, '0, 1, 1, 0);
        cyc(0, 0, 0, '0, 1, 1, 0);
        cyc(0, 0, 0, '0, 1, 1, 0);
        @(posedge clk);
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
